// File: rtl/skullfet_tester.sv
// Built-in self-test sequencer for a single skullfet_inverter cell.
// Drives A with a circulating pattern or an 8-bit Galois LFSR stream, waits
// SETTLE_CYCLES, samples the synchronised Y and accumulates error statistics.
//
// Handshake: start is level-sampled only in IDLE (ignored while a run is in
// progress); abort ends any non-idle state on the next edge and suppresses
// the done pulse; done is a one-cycle pulse issued only on normal completion.
//
// The LFSR mode uses pattern[7:0] as seed, so PATTERN_W must be at least 8.
module skullfet_tester #(
    parameter int SETTLE_CYCLES = 4,
    parameter int CNT_W         = 16,
    parameter int PATTERN_W     = 8
) (
    input  logic                 wb_clk_i,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 mode,
    input  logic [PATTERN_W-1:0] pattern,
    input  logic [CNT_W-1:0]     num_vectors,
    output logic                 cell_a,
    input  logic                 cell_y,
    output logic                 busy,
    output logic                 done,
    output logic                 pass,
    output logic [CNT_W-1:0]     vec_count,
    output logic [CNT_W-1:0]     err_count,
    output logic [CNT_W-1:0]     first_fail,
    output logic [2:0]           fsm_state
);

    localparam int SET_W = (SETTLE_CYCLES > 2) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int IDX_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;
    localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST    = IDX_W'(PATTERN_W - 1);
    localparam logic [7:0]       LFSR_MASK   = 8'hB8;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_DRIVE  = 3'd1,
        S_SETTLE = 3'd2,
        S_SAMPLE = 3'd3,
        S_DONE   = 3'd4
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic                   rst_meta;
    logic                   rst_int_n;
    logic                   y_meta;
    logic                   y_s;
    logic                   mode_q;
    logic [PATTERN_W-1:0]   pat_q;
    logic [CNT_W-1:0]       nv_q;
    logic [IDX_W-1:0]       pat_idx;
    logic [7:0]             lfsr;
    logic [SET_W-1:0]       settle_cnt;
    logic                   accept;
    logic                   kill;
    logic                   mismatch;
    logic                   last_vec;
    logic [7:0]             seed;
    logic [CNT_W-1:0]       vec_inc;

    assign fsm_state = state;
    assign accept    = (state == S_IDLE) && start && !abort;
    assign kill      = (state != S_IDLE) && abort;
    assign mismatch  = (y_s == cell_a);
    assign vec_inc   = vec_count + CNT_W'(1);
    assign last_vec  = (vec_inc == nv_q);
    assign seed      = (pattern[7:0] == 8'h00) ? 8'h01 : pattern[7:0];

    // Reset bridge: assert asynchronously, release on a clock edge.
    always_ff @(posedge wb_clk_i or negedge rst_n) begin
        if (!rst_n) begin
            rst_meta  <= 1'b0;
            rst_int_n <= 1'b0;
        end else begin
            rst_meta  <= 1'b1;
            rst_int_n <= rst_meta;
        end
    end

    // Two-flop synchroniser for the asynchronous cell output.
    always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            y_meta <= 1'b0;
            y_s    <= 1'b0;
        end else begin
            y_meta <= cell_y;
            y_s    <= y_meta;
        end
    end

    // FSM state register.
    always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; abort overrides every non-idle transition.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_nxt = (num_vectors == '0) ? S_DONE : S_DRIVE;
                end
            end
            S_DRIVE:  state_nxt = S_SETTLE;
            S_SETTLE: begin
                if (settle_cnt == '0) begin
                    state_nxt = S_SAMPLE;
                end
            end
            S_SAMPLE: state_nxt = last_vec ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
        if (kill) begin
            state_nxt = S_IDLE;
        end
    end

    // Datapath: configuration latch, stimulus, settle timer and statistics.
    always_ff @(posedge wb_clk_i or negedge rst_int_n) begin
        if (!rst_int_n) begin
            cell_a     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            vec_count  <= '0;
            err_count  <= '0;
            first_fail <= '1;
            mode_q     <= 1'b0;
            pat_q      <= '0;
            nv_q       <= '0;
            pat_idx    <= '0;
            lfsr       <= 8'h01;
            settle_cnt <= '0;
        end else begin
            done <= 1'b0;
            if (kill) begin
                busy   <= 1'b0;
                cell_a <= 1'b0;
                pass   <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (accept) begin
                            mode_q     <= mode;
                            pat_q      <= pattern;
                            nv_q       <= num_vectors;
                            vec_count  <= '0;
                            err_count  <= '0;
                            first_fail <= '1;
                            pass       <= 1'b0;
                            pat_idx    <= '0;
                            lfsr       <= seed;
                            busy       <= (num_vectors != '0);
                        end
                    end
                    S_DRIVE: begin
                        cell_a     <= mode_q ? lfsr[0] : pat_q[pat_idx];
                        settle_cnt <= SETTLE_LOAD;
                    end
                    S_SETTLE: begin
                        if (settle_cnt != '0) begin
                            settle_cnt <= settle_cnt - SET_W'(1);
                        end
                    end
                    S_SAMPLE: begin
                        if (mismatch) begin
                            if (err_count != '1) begin
                                err_count <= err_count + CNT_W'(1);
                            end
                            if (err_count == '0) begin
                                first_fail <= vec_count;
                            end
                        end
                        vec_count <= vec_inc;
                        pat_idx   <= (pat_idx == IDX_LAST) ? '0 : pat_idx + IDX_W'(1);
                        if (mode_q) begin
                            lfsr <= (lfsr >> 1) ^ (lfsr[0] ? LFSR_MASK : 8'h00);
                        end
                    end
                    S_DONE: begin
                        done <= 1'b1;
                        pass <= (err_count == '0);
                        busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_skullfet_tester.sv
// Directed bench for skullfet_tester: table of complete runs on a 16-bit
// instance plus hand-written abort, start/abort and async-reset sequences,
// the last on a CNT_W=4 instance.
module tb_skullfet_tester;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic        abort;
    logic        mode;
    logic [7:0]  pattern;
    logic [15:0] num_vectors;
    logic        cell_a;
    logic        cell_y;
    logic        busy;
    logic        done;
    logic        pass;
    logic [15:0] vec_count;
    logic [15:0] err_count;
    logic [15:0] first_fail;
    logic [2:0]  fsm_state;

    logic        rst4_n;
    logic        start4;
    logic        abort4;
    logic        mode4;
    logic [7:0]  pattern4;
    logic [3:0]  nv4;
    logic        cell_a4;
    logic        cell_y4;
    logic        busy4;
    logic        done4;
    logic        pass4;
    logic [3:0]  vec4;
    logic [3:0]  err4;
    logic [3:0]  ff4;
    logic [2:0]  state4;

    // 0 = ideal inverter with one cycle of delay, 1 = stuck-at-0, 2 = stuck-at-1
    int          y_mode;
    logic        ideal_q;

    int          checks;
    int          failures;
    logic        busy_seen;
    logic [15:0] vec_at_start;
    logic [15:0] err_at_start;
    logic [15:0] ff_at_start;
    logic        a_q[$];

    typedef struct {
        string       name;
        logic        mode;
        logic [7:0]  pat;
        logic [15:0] nv;
        int          ymode;
        int          exp_cyc;
        logic        exp_pass;
        logic [15:0] exp_err;
        logic [15:0] exp_ff;
    } run_t;

    run_t tbl[7];

    skullfet_tester #(.SETTLE_CYCLES(4), .CNT_W(16), .PATTERN_W(8)) dut (
        .wb_clk_i(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .mode(mode), .pattern(pattern), .num_vectors(num_vectors),
        .cell_a(cell_a), .cell_y(cell_y), .busy(busy), .done(done),
        .pass(pass), .vec_count(vec_count), .err_count(err_count),
        .first_fail(first_fail), .fsm_state(fsm_state)
    );

    skullfet_tester #(.SETTLE_CYCLES(4), .CNT_W(4), .PATTERN_W(8)) dut4 (
        .wb_clk_i(clk), .rst_n(rst4_n), .start(start4), .abort(abort4),
        .mode(mode4), .pattern(pattern4), .num_vectors(nv4),
        .cell_a(cell_a4), .cell_y(cell_y4), .busy(busy4), .done(done4),
        .pass(pass4), .vec_count(vec4), .err_count(err4),
        .first_fail(ff4), .fsm_state(state4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) ideal_q <= ~cell_a;

    always_comb begin
        cell_y = ideal_q;
        if (y_mode == 1) cell_y = 1'b0;
        if (y_mode == 2) cell_y = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Launches one run on the 16-bit instance and waits for done.
    // cyc returns the number of edges from the start edge to done rising.
    task automatic run_case(input logic m, input logic [7:0] p, input logic [15:0] nv,
                            input int ym, output int cyc, output logic got);
        @(negedge clk);
        mode = m; pattern = p; num_vectors = nv; y_mode = ym; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        // scramble live config to show only latched copies matter
        pattern = ~p; num_vectors = nv + 16'd3; mode = ~m;
        busy_seen = busy;
        vec_at_start = vec_count; err_at_start = err_count; ff_at_start = first_fail;
        a_q.delete();
        cyc = 0; got = 1'b0;
        while (!got && cyc < 2000) begin
            @(posedge clk);
            cyc++;
            @(negedge clk);
            if (busy) busy_seen = 1'b1;
            if (cyc % 6 == 1) a_q.push_back(cell_a);
            if (done) got = 1'b1;
        end
        if (!got) begin
            checks++; failures++;
            $display("FAIL done_timeout: got no done after %0d cycles", cyc);
        end
    endtask

    initial begin
        int          cyc;
        logic        got;
        logic [15:0] seq;
        checks = 0; failures = 0;
        rst_n = 1'b0; rst4_n = 1'b0;
        start = 1'b0; abort = 1'b0; mode = 1'b0; pattern = 8'h00; num_vectors = 16'd0;
        start4 = 1'b0; abort4 = 1'b0; mode4 = 1'b0; pattern4 = 8'hFF; nv4 = 4'd0;
        cell_y4 = 1'b1; y_mode = 0;

        tbl[0] = '{"ideal_a5",   1'b0, 8'hA5, 16'd16, 0, 97, 1'b1, 16'd0, 16'hFFFF};
        tbl[1] = '{"stuck0_00",  1'b0, 8'h00, 16'd8,  1, 49, 1'b0, 16'd8, 16'h0000};
        tbl[2] = '{"stuck0_ff",  1'b0, 8'hFF, 16'd8,  1, 49, 1'b1, 16'd0, 16'hFFFF};
        tbl[3] = '{"lfsr_seed0", 1'b1, 8'h00, 16'd5,  0, 31, 1'b1, 16'd0, 16'hFFFF};
        tbl[4] = '{"stuck1_f0",  1'b0, 8'hF0, 16'd8,  2, 49, 1'b0, 16'd4, 16'h0004};
        tbl[5] = '{"zero_vec",   1'b0, 8'h5A, 16'd0,  0, 1,  1'b1, 16'd0, 16'hFFFF};
        tbl[6] = '{"lfsr_stuck0",1'b1, 8'h01, 16'd10, 1, 61, 1'b0, 16'd6, 16'h0001};

        // Reset values while reset is held
        @(negedge clk);
        chk("rst_cell_a", 32'(cell_a), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        chk("rst_vec", 32'(vec_count), 32'd0);
        chk("rst_err", 32'(err_count), 32'd0);
        chk("rst_ff", 32'(first_fail), 32'hFFFF);
        chk("rst_state", 32'(fsm_state), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1; rst4_n = 1'b1;
        repeat (4) @(negedge clk);

        // Table of complete runs
        for (int i = 0; i < 7; i++) begin
            run_case(tbl[i].mode, tbl[i].pat, tbl[i].nv, tbl[i].ymode, cyc, got);
            chk({tbl[i].name, "_cycles"}, 32'(cyc), 32'(tbl[i].exp_cyc));
            chk({tbl[i].name, "_pass"}, 32'(pass), 32'(tbl[i].exp_pass));
            chk({tbl[i].name, "_err"}, 32'(err_count), 32'(tbl[i].exp_err));
            chk({tbl[i].name, "_vec"}, 32'(vec_count), 32'(tbl[i].nv));
            chk({tbl[i].name, "_ff"}, 32'(first_fail), 32'(tbl[i].exp_ff));
            chk({tbl[i].name, "_busy_seen"}, 32'(busy_seen), 32'(tbl[i].nv != 16'd0));
            chk({tbl[i].name, "_busy_end"}, 32'(busy), 32'd0);
            if (i == 0) begin
                seq = 16'hA5A5;
                for (int k = 0; k < 16; k++)
                    chk($sformatf("a5_cell_a_%0d", k),
                        32'((k < a_q.size()) ? a_q[k] : 1'bx), 32'(seq[k]));
            end
            if (i == 3) begin
                seq = 16'b10001;
                for (int k = 0; k < 5; k++)
                    chk($sformatf("lfsr_cell_a_%0d", k),
                        32'((k < a_q.size()) ? a_q[k] : 1'bx), 32'(seq[k]));
            end
            @(negedge clk);
            chk({tbl[i].name, "_done_width"}, 32'(done), 32'd0);
        end

        // Abort in SETTLE of vector 3: stuck-at-1, pattern FF -> every vector fails
        @(negedge clk);
        mode = 1'b0; pattern = 8'hFF; num_vectors = 16'd10; y_mode = 2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (cyc < 20) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        chk("abort_pre_cell_a", 32'(cell_a), 32'd1);
        chk("abort_pre_busy", 32'(busy), 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_cell_a", 32'(cell_a), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        chk("abort_vec", 32'(vec_count), 32'd3);
        chk("abort_err", 32'(err_count), 32'd3);
        chk("abort_ff", 32'(first_fail), 32'd0);
        got = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("abort_no_done", 32'(got), 32'd0);
        chk("abort_hold_vec", 32'(vec_count), 32'd3);

        // New start after abort clears counters and runs normally
        run_case(1'b0, 8'h3C, 16'd4, 0, cyc, got);
        chk("restart_vec_clr", 32'(vec_at_start), 32'd0);
        chk("restart_err_clr", 32'(err_at_start), 32'd0);
        chk("restart_ff_set", 32'(ff_at_start), 32'hFFFF);
        chk("restart_cycles", 32'(cyc), 32'd25);
        chk("restart_pass", 32'(pass), 32'd1);
        chk("restart_vec", 32'(vec_count), 32'd4);

        // start and abort together in IDLE: start ignored, results kept
        @(negedge clk);
        num_vectors = 16'd2; start = 1'b1; abort = 1'b1;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        chk("startabort_busy", 32'(busy), 32'd0);
        chk("startabort_state", 32'(fsm_state), 32'd0);
        chk("startabort_vec", 32'(vec_count), 32'd4);
        chk("startabort_pass", 32'(pass), 32'd1);
        got = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done) got = 1'b1;
        end
        chk("startabort_no_done", 32'(got), 32'd0);

        // CNT_W=4 instance: 15 failing vectors saturate err_count at 15
        @(negedge clk);
        nv4 = 4'd15; start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0; got = 1'b0;
        while (!got && cyc < 500) begin
            @(posedge clk); cyc++; @(negedge clk);
            if (done4) got = 1'b1;
        end
        chk("w4_got_done", 32'(got), 32'd1);
        chk("w4_cycles", 32'(cyc), 32'd91);
        chk("w4_err_sat", 32'(err4), 32'd15);
        chk("w4_vec", 32'(vec4), 32'd15);
        chk("w4_ff", 32'(ff4), 32'd0);
        chk("w4_pass", 32'(pass4), 32'd0);
        repeat (3) @(negedge clk);
        chk("w4_err_hold", 32'(err4), 32'd15);

        // Second run, async reset in the SETTLE of vector 1
        start4 = 1'b1;
        @(negedge clk);
        start4 = 1'b0;
        cyc = 0;
        while (cyc < 9) begin
            @(posedge clk); cyc++; @(negedge clk);
        end
        chk("w4_pre_busy", 32'(busy4), 32'd1);
        chk("w4_pre_cell_a", 32'(cell_a4), 32'd1);
        chk("w4_pre_err", 32'(err4), 32'd1);
        #1 rst4_n = 1'b0;
        #1;
        chk("w4_rst_cell_a", 32'(cell_a4), 32'd0);
        chk("w4_rst_busy", 32'(busy4), 32'd0);
        chk("w4_rst_done", 32'(done4), 32'd0);
        chk("w4_rst_pass", 32'(pass4), 32'd0);
        chk("w4_rst_vec", 32'(vec4), 32'd0);
        chk("w4_rst_err", 32'(err4), 32'd0);
        chk("w4_rst_ff", 32'(ff4), 32'hF);
        chk("w4_rst_state", 32'(state4), 32'd0);
        #1 rst4_n = 1'b1;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
